mvm_arbiter: RTL and testbench
==============================

MVM_ARBITER -- requirements
Module: mvm_arbiter

Interface
REQ-001: Parameters SHALL be K (default 8; matrix dimension; engine computes K outputs per job) and B (default 16; input word width).
REQ-002: clk  input  1  sole clock; all state changes on rising edge.
REQ-003: reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004: req0, req1  input  1 each  requester r wants one engine job; held high until grant_r.
REQ-005: mat0, mat1  input  1 each  sampled with req_r: 1 = job includes a K*K matrix reload, 0 = reuse the resident matrix.
REQ-006: in_valid0/1  input  1; in_data0/1  input  B  requester input word stream.
REQ-007: in_ready0/1  output  1  arbiter accepts in_data_r this cycle.
REQ-008: grant0/1  output  1  high for the whole job owned by requester r.
REQ-009: nack0/1  output  1  one-cycle pulse: job rejected.
REQ-010: err0/1  output  1  sticky input-gap flag; cleared on the next grant_r.
REQ-011: out_valid0/1  output  1; out_data0/1  output  2B  result stream (no backpressure).
REQ-012: eng_loadMatrix, eng_loadVector, eng_start  output  1 each  one-cycle engine command pulses.
REQ-013: eng_data_in  output  B  word to engine; eng_done  input  1  engine completion pulse; eng_data_out  input  2B  engine results.

Function
REQ-014: Engine contract: words follow a load pulse on the next K*K (matrix) or K (vector) consecutive cycles; results occupy the K consecutive cycles after eng_done.
REQ-015: FSM states: IDLE, M_CMD, M_LOAD, V_CMD, V_LOAD, START, WAIT, DRAIN.
REQ-016: IDLE: pick requester r with req_r high; if both, pick the one not served last (pointer init after reset favours 0); go to M_CMD if mat_r=1, else V_CMD.
REQ-017: Reject rule: mat_r=0 and resident-matrix owner != r (or no valid matrix) -> nack_r for 1 cycle, no grant, no engine command, stay IDLE, pointer updated as if served.
REQ-018: grant_r rises the cycle after selection; it falls the cycle after the last DRAIN cycle.
REQ-019: M_CMD: eng_loadMatrix=1 for 1 cycle; then M_LOAD for exactly K*K cycles; then V_CMD.
REQ-020: V_CMD: eng_loadVector=1 for 1 cycle; then V_LOAD for exactly K cycles; then START.
REQ-021: In M_LOAD/V_LOAD: in_ready_r=1; eng_data_in=in_data_r when in_valid_r=1.
REQ-022: Otherwise eng_data_in=0 and err_r set, with no lengthening of the phase.
REQ-023: START: eng_start=1 for 1 cycle -> WAIT; WAIT holds until eng_done=1 -> DRAIN.
REQ-024: DRAIN: K cycles; out_valid_r=1, out_data_r=eng_data_out; the other requester's out_valid=0; then IDLE.
REQ-025: After M_LOAD completes, matrix owner=r and matrix valid=1.
REQ-026: The arbiter SHALL ignore req changes while a job is in progress; all command pulses occur only in their states; in_ready/out_valid are 0 outside the owning job.
REQ-027: Counters SHALL be sized for K*K-1 and wrap to 0 on phase exit; no off-by-one (exactly K*K and K words forwarded).
REQ-028: eng_done outside WAIT SHALL be ignored.

Reset
REQ-029: reset=0 at a clock edge -> state IDLE, all outputs 0, counters 0, matrix valid 0, err0/1 0, pointer favours requester 0; an in-flight job is abandoned silently.

Verification
REQ-030: req0=1,mat0=1, 72 gapless words 1..72 -> loadMatrix 1 cycle after grant0, 64 words forwarded, loadVector, 8 words, start; 8 results on out_data0 after eng_done; err0=0.
REQ-031: req0 and req1 both high from reset with mat=1 -> requester 0 served first, requester 1 immediately after; then simultaneous again -> 0 served next (alternation).
REQ-032: After requester 0 loads matrix, req1=1,mat1=0 -> nack1 one cycle, no engine pulse; req0=1,mat0=0 -> accepted, no loadMatrix, 8 vector words only.
REQ-033: in_valid0 low for cycle 10 of M_LOAD -> eng_data_in=0 that cycle, phase still 64 cycles, err0=1 until next grant0.
REQ-034: reset=0 during WAIT -> next cycle all outputs 0, IDLE; a subsequent mat=0 job is rejected (matrix invalid).
REQ-035: eng_done pulsed during M_LOAD -> ignored; job completes normally with exactly 8 out_valid cycles.

Source files
------------

// File: rtl/mvm_arbiter.sv
// Two-requester arbiter that time-shares one matrix-vector engine.
// Keeps track of which requester owns the matrix resident in the engine.
module mvm_arbiter #(
   parameter int K = 8,
   parameter int B = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req0,
   input  logic           req1,
   input  logic           mat0,
   input  logic           mat1,
   input  logic           in_valid0,
   input  logic           in_valid1,
   input  logic [B-1:0]   in_data0,
   input  logic [B-1:0]   in_data1,
   output logic           in_ready0,
   output logic           in_ready1,
   output logic           grant0,
   output logic           grant1,
   output logic           nack0,
   output logic           nack1,
   output logic           err0,
   output logic           err1,
   output logic           out_valid0,
   output logic           out_valid1,
   output logic [2*B-1:0] out_data0,
   output logic [2*B-1:0] out_data1,
   output logic           eng_loadMatrix,
   output logic           eng_loadVector,
   output logic           eng_start,
   output logic [B-1:0]   eng_data_in,
   input  logic           eng_done,
   input  logic [2*B-1:0] eng_data_out,
   output logic [2:0]     dbg_state
);

   // Handshake: a requester holds req until it sees grant (accepted) or
   // nack (rejected); input words are consumed whenever in_ready is high,
   // and a low in_valid while in_ready is high is a gap, never a stall.

   localparam int MM = K * K;
   localparam int CW = (MM > 1) ? $clog2(MM) : 1;

   typedef enum logic [2:0] {
      IDLE, M_CMD, M_LOAD, V_CMD, V_LOAD, START, WAIT, DRAIN
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          own, own_n;
   logic          prio, prio_n;
   logic          mval, mval_n;
   logic          mown, mown_n;
   logic [1:0]    err_q, err_n;
   logic [1:0]    nack_q, nack_n;
   logic [1:0]    req, mat, iv;
   logic          pick;
   logic          loading;
   logic          busy;

   assign req = {req1, req0};
   assign mat = {mat1, mat0};
   assign iv  = {in_valid1, in_valid0};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         own    <= 1'b0;
         prio   <= 1'b0;
         mval   <= 1'b0;
         mown   <= 1'b0;
         err_q  <= '0;
         nack_q <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         own    <= own_n;
         prio   <= prio_n;
         mval   <= mval_n;
         mown   <= mown_n;
         err_q  <= err_n;
         nack_q <= nack_n;
      end
   end

   always_comb begin
      state_n        = state;
      cnt_n          = cnt;
      own_n          = own;
      prio_n         = prio;
      mval_n         = mval;
      mown_n         = mown;
      err_n          = err_q;
      nack_n         = '0;
      loading        = 1'b0;
      eng_loadMatrix = 1'b0;
      eng_loadVector = 1'b0;
      eng_start      = 1'b0;
      eng_data_in    = '0;
      pick           = (req == 2'b11) ? prio : req[1];

      case (state)
         IDLE: begin
            // Selection pauses while a nack is shown so the rejected
            // requester has a cycle to drop its request.
            if (req != 2'b00 && nack_q == 2'b00) begin
               prio_n = ~pick;
               if (!mat[pick] && !(mval && mown == pick)) begin
                  nack_n[pick] = 1'b1;
               end else begin
                  own_n       = pick;
                  err_n[pick] = 1'b0;
                  state_n     = mat[pick] ? M_CMD : V_CMD;
               end
            end
         end
         M_CMD: begin
            eng_loadMatrix = 1'b1;
            mval_n         = 1'b0;
            state_n        = M_LOAD;
         end
         M_LOAD: begin
            loading = 1'b1;
            if (cnt == CW'(MM - 1)) begin
               cnt_n   = '0;
               mval_n  = 1'b1;
               mown_n  = own;
               state_n = V_CMD;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         V_CMD: begin
            eng_loadVector = 1'b1;
            state_n        = V_LOAD;
         end
         V_LOAD: begin
            loading = 1'b1;
            if (cnt == CW'(K - 1)) begin
               cnt_n   = '0;
               state_n = START;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         START: begin
            eng_start = 1'b1;
            state_n   = WAIT;
         end
         WAIT: begin
            if (eng_done) state_n = DRAIN;
         end
         DRAIN: begin
            if (cnt == CW'(K - 1)) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      // A gap forwards zero and flags the owner; the phase length is fixed.
      if (loading) begin
         if (iv[own]) eng_data_in = own ? in_data1 : in_data0;
         else         err_n[own]  = 1'b1;
      end
   end

   assign busy       = (state != IDLE);
   assign grant0     = busy && !own;
   assign grant1     = busy && own;
   assign in_ready0  = loading && !own;
   assign in_ready1  = loading && own;
   assign out_valid0 = (state == DRAIN) && !own;
   assign out_valid1 = (state == DRAIN) && own;
   assign out_data0  = out_valid0 ? eng_data_out : '0;
   assign out_data1  = out_valid1 ? eng_data_out : '0;
   assign nack0      = nack_q[0];
   assign nack1      = nack_q[1];
   assign err0       = err_q[0];
   assign err1       = err_q[1];
   assign dbg_state  = state;

endmodule

// File: tb/tb_mvm_arbiter.sv
// Directed bench for mvm_arbiter: fixed-timing job sequences with
// hand-derived expected command pulses, forwarded words and results.
module tb_mvm_arbiter;

   localparam int K = 8;
   localparam int B = 16;

   // clock / reset
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]     req_v = '0, mat_v = '0, iv_v = '0;
   logic [B-1:0]   id_v [2];
   logic           eng_done = 1'b0;
   logic [2*B-1:0] eng_data_out = '0;

   logic in_ready0, in_ready1, grant0, grant1, nack0, nack1, err0, err1;
   logic out_valid0, out_valid1, eng_loadMatrix, eng_loadVector, eng_start;
   logic [2*B-1:0] out_data0, out_data1;
   logic [B-1:0]   eng_data_in;
   logic [2:0]     dbg_state;

   mvm_arbiter #(.K(K), .B(B)) dut (
      .clk(clk), .reset(reset),
      .req0(req_v[0]), .req1(req_v[1]), .mat0(mat_v[0]), .mat1(mat_v[1]),
      .in_valid0(iv_v[0]), .in_valid1(iv_v[1]),
      .in_data0(id_v[0]), .in_data1(id_v[1]),
      .in_ready0(in_ready0), .in_ready1(in_ready1),
      .grant0(grant0), .grant1(grant1), .nack0(nack0), .nack1(nack1),
      .err0(err0), .err1(err1),
      .out_valid0(out_valid0), .out_valid1(out_valid1),
      .out_data0(out_data0), .out_data1(out_data1),
      .eng_loadMatrix(eng_loadMatrix), .eng_loadVector(eng_loadVector),
      .eng_start(eng_start), .eng_data_in(eng_data_in),
      .eng_done(eng_done), .eng_data_out(eng_data_out),
      .dbg_state(dbg_state)
   );

   wire [1:0] grant_w = {grant1, grant0};
   wire [1:0] nack_w  = {nack1, nack0};
   wire [1:0] err_w   = {err1, err0};
   wire [1:0] ready_w = {in_ready1, in_ready0};
   wire [1:0] valid_w = {out_valid1, out_valid0};
   wire [2:0] cmd_w   = {eng_loadMatrix, eng_loadVector, eng_start};

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] oh(input int r);
      return (r == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_flags"}, {grant_w, nack_w, err_w, ready_w, valid_w, cmd_w}, 64'd0);
      chk({tag, "_data"}, {out_data0, out_data1, eng_data_in}, 64'd0);
      chk({tag, "_state"}, dbg_state, 64'd0);
   endtask

   // driver: one complete accepted job for requester r
   task automatic do_job(input int r, input bit raise, input bit mat, input int gap,
                         input int done_at, input bit abort, input logic [31:0] rbase);
      logic [1:0]   o;
      logic [B-1:0] w;
      o = oh(r);
      if (raise) begin
         tick();
         req_v[r] = 1'b1;
         mat_v[r] = mat;
      end
      tick(); #1;
      chk("grant", grant_w, o);
      chk("err_cleared", err_w & o, 0);
      chk("nack_on_grant", nack_w, 0);
      chk("loadMatrix_on_grant", eng_loadMatrix, mat);
      chk("loadVector_on_grant", eng_loadVector, !mat);
      req_v[r] = 1'b0;
      if (mat) begin
         for (int i = 0; i < K*K; i++) begin
            tick();
            w = B'(i + 1);
            id_v[r] = w;
            id_v[1-r] = 16'hdead;
            iv_v = (i == gap) ? 2'b00 : o;
            eng_done = (i == done_at);
            #1;
            chk("m_ready", ready_w, o);
            chk("m_data", eng_data_in, (i == gap) ? B'(0) : w);
            chk("m_cmd", cmd_w, 0);
         end
         tick();
         eng_done = 1'b0;
         iv_v = 2'b00;
         #1;
         chk("loadVector", cmd_w, 3'b010);
         chk("v_cmd_ready", ready_w, 0);
      end
      for (int i = 0; i < K; i++) begin
         tick();
         w = B'(K*K + 1 + i);
         id_v[r] = w;
         id_v[1-r] = 16'hbeef;
         iv_v = o;
         #1;
         chk("v_ready", ready_w, o);
         chk("v_data", eng_data_in, w);
         chk("v_cmd", cmd_w, 0);
      end
      tick();
      iv_v = 2'b00;
      #1;
      chk("start", cmd_w, 3'b001);
      chk("start_ready", ready_w, 0);
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         chk("wait_idle_out", {valid_w, cmd_w}, 0);
         chk("wait_grant", grant_w, o);
      end
      if (abort) begin
         chk("err_in_wait", err_w, (gap < K*K) ? o : 2'b00);
         tick();
         reset = 1'b0;
         tick(); #1;
         chk_all_zero("abort_reset");
         reset = 1'b1;
         return;
      end
      tick();
      eng_done = 1'b1;
      for (int j = 0; j < K; j++) begin
         tick();
         eng_done = 1'b0;
         eng_data_out = rbase + 32'(j);
         #1;
         chk("drain_valid", valid_w, o);
         chk("drain_grant", grant_w, o);
         chk("drain_data", (r == 1) ? out_data1 : out_data0, rbase + 32'(j));
         chk("drain_other_data", (r == 1) ? out_data0 : out_data1, 0);
      end
      tick();
      eng_data_out = '0;
      #1;
      chk("post_valid", valid_w, 0);
      chk("post_grant", grant_w, 0);
      chk("post_err", err_w & o, (mat && gap < K*K) ? o : 2'b00);
   endtask

   task automatic do_reject(input int r);
      logic [1:0] o;
      o = oh(r);
      tick();
      req_v[r] = 1'b1;
      mat_v[r] = 1'b0;
      tick(); #1;
      chk("nack", nack_w, o);
      chk("rej_grant", grant_w, 0);
      chk("rej_cmd", cmd_w, 0);
      req_v[r] = 1'b0;
      tick(); #1;
      chk("nack_end", nack_w, 0);
      chk("rej_grant_after", grant_w, 0);
      chk("rej_cmd_after", cmd_w, 0);
   endtask

   initial begin
      id_v[0] = '0;
      id_v[1] = '0;
      repeat (3) tick();
      #1;
      chk_all_zero("reset");
      reset = 1'b1;

      // simultaneous requests from reset: 0, then 1, then 0 again, then 1
      tick();
      req_v = 2'b11;
      mat_v = 2'b11;
      do_job(0, 1'b0, 1'b1, K*K, -1, 1'b0, 32'h0001_0000);
      do_job(1, 1'b0, 1'b1, K*K, -1, 1'b0, 32'h0002_0000);
      tick();
      req_v = 2'b11;
      mat_v = 2'b11;
      do_job(0, 1'b0, 1'b1, K*K, -1, 1'b0, 32'h0003_0000);
      do_job(1, 1'b0, 1'b1, K*K, -1, 1'b0, 32'h0004_0000);

      // gapless full job, then matrix-reuse rules
      do_job(0, 1'b1, 1'b1, K*K, -1, 1'b0, 32'h0005_0000);
      do_reject(1);
      do_job(0, 1'b1, 1'b0, K*K, -1, 1'b0, 32'h0006_0000);

      // input gap on the 10th matrix cycle, then a stray eng_done in M_LOAD
      do_job(0, 1'b1, 1'b1, 9, -1, 1'b0, 32'h0007_0000);
      do_job(0, 1'b1, 1'b1, K*K, 20, 1'b0, 32'h0008_0000);

      // reset while waiting on the engine invalidates the matrix
      do_job(0, 1'b1, 1'b1, 9, -1, 1'b1, 32'h0009_0000);
      do_reject(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
